// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared constants and state type for the round-robin hold arbiter
package arbiter_pkg;

  localparam int ROWS         = 4;
  localparam int DEF_HOLD_MAX = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - combinational lowest-index-first picker, one-hot plus binary index out
module rr_prio_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// rtl/rr_hold_arbiter.sv - registered round-robin arbiter holding grant until ack
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN.
module rr_hold_arbiter
  import arbiter_pkg::*;
#(
  parameter int N        = ROWS,
  parameter int IDX_W    = $clog2(N),
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [N-1:0]     req_i,
  input  logic             ack_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             timeout_o
);

  if (N < 2) begin : g_bad_n
    $error("rr_hold_arbiter: N must be >= 2");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("rr_hold_arbiter: HOLD_MAX must be >= 1");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

  logic [IDX_W-1:0] arb_ptr;
  logic [N-1:0]     arb_req, arb_mask, masked_req;
  logic [N-1:0]     m_gnt, a_gnt, win_gnt;
  logic [IDX_W-1:0] m_idx, a_idx, win_idx;
  logic             timeout_hit, revoke, load_grant;

  // While granting, the mask is built from the current winner so an ack
  // re-arbitrates against the rotated pointer in the same cycle.
  always_comb begin
    arb_ptr = (state_q == GRANT) ? gnt_idx_q : ptr_q;
    arb_req = (state_q == GRANT) ? (req_i & ~gnt_q) : req_i;
    arb_mask = '0;
    for (int i = 0; i < N; i++) begin
      arb_mask[i] = (IDX_W'(i) > arb_ptr);
    end
    masked_req = arb_req & arb_mask;
  end

  rr_prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick_masked (
    .req_i (masked_req),
    .gnt_o (m_gnt),
    .idx_o (m_idx)
  );

  rr_prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick_all (
    .req_i (arb_req),
    .gnt_o (a_gnt),
    .idx_o (a_idx)
  );

  assign win_gnt = (|masked_req) ? m_gnt : a_gnt;
  assign win_idx = (|masked_req) ? m_idx : a_idx;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    revoke     = 1'b0;
    load_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d      = win_gnt;
          gnt_idx_d  = win_idx;
          state_d    = GRANT;
          load_grant = 1'b1;
        end
      end
      GRANT: begin
        if (ack_i || (req_i[gnt_idx_q] && timeout_hit)) begin
          revoke = !ack_i;
          ptr_d  = gnt_idx_q;
          if (|arb_req) begin
            gnt_d      = win_gnt;
            gnt_idx_d  = win_idx;
            load_grant = 1'b1;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (!req_i[gnt_idx_q]) begin
          ptr_d   = gnt_idx_q;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(N - 1);
      gnt_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  assign timeout_hit = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    timeout_d  = revoke;
    if (load_grant) begin
      hold_cnt_d = '0;
    end else if (state_q == GRANT) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = revoke | load_grant;
  assign timeout_o      = 1'b0;
`endif

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign gnt_idx_o   = gnt_idx_q;

endmodule
